// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Imported by the fetch queue and the fetch unit top.
package fetch_pkg;

  localparam int          INSTR_W          = 32;
  localparam int          PC_W             = 32;
  localparam logic [31:0] PC_INC           = 32'd4;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic {
    BOOT = 1'b0,
    RUN  = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

  // Fetch addresses are always word aligned; low address bits are dropped.
  function automatic logic [PC_W-1:0] align_pc(input logic [PC_W-1:0] pc);
    return pc & ~32'h0000_0003;
  endfunction

endpackage

// File: rtl/fetch_fifo2.sv
// Two-entry {pc, instr} queue between instruction memory and the consumer.
// Entry 0 is always the head, so the head output comes straight from a flop.
module fetch_fifo2
  import fetch_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  fetch_entry_t push_entry,
  input  logic         pop,
  input  logic         flush,
  output fetch_entry_t head,
  output logic [1:0]   count
);

  fetch_entry_t entry_q [2];
  fetch_entry_t entry_d [2];
  logic [1:0]   count_q;
  logic [1:0]   count_d;
  logic         pop_ok;
  logic [1:0]   kept;

  always_comb begin
    entry_d = entry_q;
    count_d = count_q;
    pop_ok  = pop && (count_q != 2'd0);
    kept    = count_q - {1'b0, pop_ok};
    if (flush) begin
      count_d = 2'd0;
    end else begin
      if (pop_ok) begin
        entry_d[0] = entry_q[1];
      end
      // A push lands directly behind whatever survives this cycle's pop.
      if (push && (kept != 2'd2)) begin
        entry_d[kept[0]] = push_entry;
        count_d          = kept + 2'd1;
      end else begin
        count_d = kept;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        entry_q[i] <= '0;
      end
    end else begin
      count_q <= count_d;
      entry_q <= entry_d;
    end
  end

  assign head  = entry_q[0];
  assign count = count_q;

endmodule

// File: rtl/ifetch_unit.sv
// Fetch stage: owns the fetch PC, issues word reads to a one-cycle memory
// and hands instructions downstream through a 2-entry queue with redirect flush.
module ifetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        Clk,
  input  logic        Reset_n,
  output logic        Imem_Req,
  output logic [31:0] Imem_Addr,
  input  logic [31:0] Imem_Data,
  input  logic        Redirect,
  input  logic [31:0] Redirect_PC,
  output logic        Instr_Valid,
  input  logic        Instr_Ready,
  output logic [31:0] Instr,
  output logic [31:0] Instr_PC
);

  fetch_state_e state_q;
  fetch_state_e state_d;
  logic [31:0]  fpc_q;
  logic [31:0]  fpc_d;
  logic [31:0]  req_pc_q;
  logic [31:0]  req_pc_d;
  logic         inflight_q;
  logic         inflight_d;

  logic         deq;
  logic         req;
  logic [2:0]   occupancy;
  logic [1:0]   count;
  fetch_entry_t head;
  fetch_entry_t ret_entry;

  always_comb begin
    deq       = (count != 2'd0) && Instr_Ready && !Redirect;
    // Slots already committed once this cycle's dequeue is taken into account.
    occupancy = {1'b0, count} + {2'b00, inflight_q} - {2'b00, deq};
    req       = (state_q == RUN) && !Redirect && (occupancy <= 3'd1);

    state_d    = RUN;
    fpc_d      = fpc_q;
    req_pc_d   = req_pc_q;
    inflight_d = req;
    if (Redirect) begin
      fpc_d = align_pc(Redirect_PC);
    end else if (req) begin
      fpc_d    = fpc_q + PC_INC;
      req_pc_d = fpc_q;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q    <= BOOT;
      fpc_q      <= RESET_PC;
      req_pc_q   <= RESET_PC;
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      fpc_q      <= fpc_d;
      req_pc_q   <= req_pc_d;
      inflight_q <= inflight_d;
    end
  end

  // A response whose cycle carries a redirect is dropped by the queue flush.
  assign ret_entry = '{pc: req_pc_q, instr: Imem_Data};

  fetch_fifo2 u_fifo (
    .clk       (Clk),
    .rst_n     (Reset_n),
    .push      (inflight_q),
    .push_entry(ret_entry),
    .pop       (deq),
    .flush     (Redirect),
    .head      (head),
    .count     (count)
  );

  assign Imem_Req    = req;
  assign Imem_Addr   = fpc_q;
  assign Instr_Valid = (count != 2'd0) && !Redirect;
  assign Instr       = head.instr;
  assign Instr_PC    = head.pc;

endmodule

// File: tb/tb_ifetch_unit.sv
// Randomized bench for ifetch_unit against a queue-of-outstanding-fetches model:
// each fetch becomes visible two cycles after its request and is delivered once, in order.
module tb_ifetch_unit;

  logic        Clk;
  logic        Reset_n;
  logic        Imem_Req;
  logic [31:0] Imem_Addr;
  logic [31:0] Imem_Data;
  logic        Redirect;
  logic [31:0] Redirect_PC;
  logic        Instr_Valid;
  logic        Instr_Ready;
  logic [31:0] Instr;
  logic [31:0] Instr_PC;

  ifetch_unit dut (
    .Clk        (Clk),
    .Reset_n    (Reset_n),
    .Imem_Req   (Imem_Req),
    .Imem_Addr  (Imem_Addr),
    .Imem_Data  (Imem_Data),
    .Redirect   (Redirect),
    .Redirect_PC(Redirect_PC),
    .Instr_Valid(Instr_Valid),
    .Instr_Ready(Instr_Ready),
    .Instr      (Instr),
    .Instr_PC   (Instr_PC)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic [31:0] pc;
    int          avail;
  } fetch_t;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic        boot = 1'b1;
  logic [31:0] exp_req_pc = 32'h0;
  fetch_t      q[$];
  int          dut_out = 0;
  logic        mem_pend = 1'b0;
  logic [31:0] mem_addr = 32'h0;

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h cyc=%0d", tag, got, exp, cyc);
    end
  endtask

  // One clock cycle: drive inputs after the edge, optionally pulse reset
  // between edges, then compare against the model on the falling edge.
  task automatic run_cycle(input logic rdy, input logic rdr, input logic [31:0] rpc,
                           input logic rst);
    logic ev;
    logic ed;
    logic er;
    @(posedge Clk);
    #1;
    Instr_Ready = rdy;
    Redirect    = rdr;
    Redirect_PC = rpc;
    Imem_Data   = mem_pend ? word_at(mem_addr) : $urandom();
    if (rst) begin
      #1 Reset_n = 1'b0;
      #1;
      check("rst_req", {31'b0, Imem_Req}, 32'h0);
      check("rst_addr", Imem_Addr, 32'h0);
      check("rst_valid", {31'b0, Instr_Valid}, 32'h0);
      check("rst_instr", Instr, 32'h0);
      check("rst_pc", Instr_PC, 32'h0);
      #1 Reset_n = 1'b1;
      q.delete();
      boot       = 1'b1;
      exp_req_pc = 32'h0;
      dut_out    = 0;
    end
    @(negedge Clk);

    ev = !Redirect && (q.size() > 0) && (q[0].avail <= cyc);
    ed = ev && Instr_Ready;
    er = !boot && !Redirect && ((q.size() - (ed ? 1 : 0)) <= 1);
    check("addr", Imem_Addr, exp_req_pc);
    check("req", {31'b0, Imem_Req}, {31'b0, er});
    check("valid", {31'b0, Instr_Valid}, {31'b0, ev});
    if (ev) begin
      check("instr_pc", Instr_PC, q[0].pc);
      check("instr", Instr, word_at(q[0].pc));
    end

    if (Redirect) begin
      q.delete();
      exp_req_pc = Redirect_PC & ~32'h3;
    end else begin
      if (ed) void'(q.pop_front());
      if (er) begin
        q.push_back('{pc: exp_req_pc, avail: cyc + 2});
        exp_req_pc = exp_req_pc + 32'd4;
      end
    end
    boot = 1'b0;

    // Requests not yet delivered, as seen on the DUT pins, must fit the queue.
    if (Redirect) dut_out = 0;
    else dut_out = dut_out + (Imem_Req ? 1 : 0) - ((Instr_Valid && Instr_Ready) ? 1 : 0);
    check("overflow", {31'b0, dut_out <= 2}, 32'h1);

    mem_pend = Imem_Req;
    mem_addr = Imem_Addr;
    cyc++;
  endtask

  initial begin
    Reset_n     = 1'b0;
    Instr_Ready = 1'b0;
    Redirect    = 1'b0;
    Redirect_PC = 32'h0;
    Imem_Data   = 32'h0;

    // Streaming with the consumer always ready.
    run_cycle(1'b1, 1'b0, 32'h0, 1'b1);
    repeat (20) run_cycle(1'b1, 1'b0, 32'h0, 1'b0);

    // Consumer stalls from cycle 3 for five cycles.
    run_cycle(1'b1, 1'b0, 32'h0, 1'b1);
    repeat (2) run_cycle(1'b1, 1'b0, 32'h0, 1'b0);
    repeat (5) run_cycle(1'b0, 1'b0, 32'h0, 1'b0);
    repeat (10) run_cycle(1'b1, 1'b0, 32'h0, 1'b0);

    // Redirect while the queue holds entries and a response is returning.
    run_cycle(1'b0, 1'b0, 32'h0, 1'b0);
    run_cycle(1'b0, 1'b1, 32'h100, 1'b0);
    repeat (8) run_cycle(1'b1, 1'b0, 32'h0, 1'b0);

    // Redirect in a cycle that would otherwise complete a handshake.
    run_cycle(1'b1, 1'b1, 32'h203, 1'b0);
    repeat (8) run_cycle(1'b1, 1'b0, 32'h0, 1'b0);

    // Reset pulse between edges mid-stream.
    run_cycle(1'b1, 1'b0, 32'h0, 1'b1);
    repeat (8) run_cycle(1'b1, 1'b0, 32'h0, 1'b0);

    // Fetch address wrap-around.
    run_cycle(1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0);
    repeat (8) run_cycle(1'b1, 1'b0, 32'h0, 1'b0);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      logic        rdy;
      logic        rdr;
      logic        rst;
      logic [31:0] rpc;
      rdy = ($urandom_range(9) < 7);
      rdr = ($urandom_range(19) == 0);
      rst = ($urandom_range(199) == 0);
      rpc = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | $urandom_range(15)) : $urandom();
      run_cycle(rdy, rdr, rpc, rst);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
